// File: rtl/i2c_xfer_seq.sv
// rtl/i2c_xfer_seq.sv - register-level transaction sequencer for the I2C byte master
//
// Expands one register write/read request into the master's
// START / WR / RESTART / RD / STOP command stream, pacing each command on the
// master's ready handshake, and reports completion, slave NACK or request error.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_i, rnw_i             request strobe (sampled in IDLE), 1 = read
//   saddr_i, reg_i           7-bit slave address, register address byte
//   len_i, wdata_i           data byte count (0..MAX_BYTES), write bytes (byte 0 first)
//   busy_o, done_o           transaction in progress, one-cycle completion pulse
//   nack_o, err_o            slave NACK seen, request rejected (len_i > MAX_BYTES)
//   rdata_o                  read bytes, byte 0 = first received
//   m_cmd_o, m_din_o, m_wr_o command, data and command strobe to the master
//   m_ready_i, m_done_i      master idle, master byte-complete tick
//   m_ack_i, m_dout_i        ACK bit (1 = NACK) and received byte, valid with m_done_i

module i2c_xfer_seq #(
    parameter int MAX_BYTES = 4,
    parameter int LW        = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic                   rnw_i,
    input  logic [6:0]             saddr_i,
    input  logic [7:0]             reg_i,
    input  logic [LW-1:0]          len_i,
    input  logic [8*MAX_BYTES-1:0] wdata_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   nack_o,
    output logic                   err_o,
    output logic [8*MAX_BYTES-1:0] rdata_o,
    output logic [2:0]             m_cmd_o,
    output logic [7:0]             m_din_o,
    output logic                   m_wr_o,
    input  logic                   m_ready_i,
    input  logic                   m_done_i,
    input  logic                   m_ack_i,
    input  logic [7:0]             m_dout_i
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT_LO = 3'd2;
    localparam logic [2:0] S_WAIT_HI = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    // Position within the command stream of the current transaction
    localparam logic [2:0] P_START   = 3'd0;
    localparam logic [2:0] P_ADDRW   = 3'd1;
    localparam logic [2:0] P_REG     = 3'd2;
    localparam logic [2:0] P_WDATA   = 3'd3;
    localparam logic [2:0] P_RESTART = 3'd4;
    localparam logic [2:0] P_ADDRR   = 3'd5;
    localparam logic [2:0] P_RD      = 3'd6;
    localparam logic [2:0] P_STOP    = 3'd7;

    localparam logic [2:0] C_START   = 3'b000;
    localparam logic [2:0] C_WR      = 3'b001;
    localparam logic [2:0] C_RD      = 3'b010;
    localparam logic [2:0] C_STOP    = 3'b011;
    localparam logic [2:0] C_RESTART = 3'b100;

    logic [2:0]             state_q;
    logic [2:0]             phase_q;
    logic                   rnw_q;
    logic [6:0]             saddr_q;
    logic [7:0]             reg_q;
    logic [LW-1:0]          len_q;
    logic [8*MAX_BYTES-1:0] wdata_q;
    logic [LW-1:0]          idx_q;
    logic [2:0]             cmd_q;
    logic [7:0]             din_q;

    logic [7:0] wbyte_c;
    logic       last_c;
    logic [2:0] cmd_c;
    logic [7:0] din_c;
    logic       is_wr_c;
    logic       ack_fail_c;

    always_comb begin
        wbyte_c = 8'h00;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (idx_q == LW'(k)) begin
                wbyte_c = wdata_q[8*k +: 8];
            end
        end
    end

    assign last_c = ((idx_q + LW'(1)) == len_q);

    always_comb begin
        cmd_c = C_START;
        din_c = 8'h00;
        case (phase_q)
            P_START:   cmd_c = C_START;
            P_ADDRW:   begin cmd_c = C_WR; din_c = {saddr_q, 1'b0}; end
            P_REG:     begin cmd_c = C_WR; din_c = reg_q; end
            P_WDATA:   begin cmd_c = C_WR; din_c = wbyte_c; end
            P_RESTART: cmd_c = C_RESTART;
            P_ADDRR:   begin cmd_c = C_WR; din_c = {saddr_q, 1'b1}; end
            P_RD:      begin cmd_c = C_RD; din_c = {7'd0, last_c}; end
            P_STOP:    cmd_c = C_STOP;
            default:   cmd_c = C_START;
        endcase
    end

    assign is_wr_c    = (phase_q == P_ADDRW) || (phase_q == P_REG) ||
                        (phase_q == P_WDATA) || (phase_q == P_ADDRR);
    assign ack_fail_c = m_done_i & is_wr_c & m_ack_i;

    // In ISSUE the command comes straight from the phase decode so it is valid
    // in the strobe cycle; the registered copy holds it until the next ISSUE.
    assign m_wr_o  = (state_q == S_ISSUE) & m_ready_i;
    assign m_cmd_o = (state_q == S_ISSUE) ? cmd_c : cmd_q;
    assign m_din_o = (state_q == S_ISSUE) ? din_c : din_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            phase_q <= P_START;
            rnw_q   <= 1'b0;
            saddr_q <= '0;
            reg_q   <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            cmd_q   <= '0;
            din_q   <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            nack_o  <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        rnw_q   <= rnw_i;
                        saddr_q <= saddr_i;
                        reg_q   <= reg_i;
                        len_q   <= len_i;
                        wdata_q <= wdata_i;
                        idx_q   <= '0;
                        phase_q <= P_START;
                        rdata_o <= '0;
                        nack_o  <= 1'b0;
                        busy_o  <= 1'b1;
                        if (len_i > LW'(MAX_BYTES)) begin
                            err_o   <= 1'b1;
                            done_o  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            err_o   <= 1'b0;
                            state_q <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (m_ready_i) begin
                        cmd_q   <= cmd_c;
                        din_q   <= din_c;
                        state_q <= S_WAIT_LO;
                    end
                end

                S_WAIT_LO, S_WAIT_HI: begin
                    // Byte results are taken in whichever wait cycle they arrive,
                    // including the one where ready rises, before the phase moves.
                    if (m_done_i) begin
                        if (ack_fail_c) begin
                            nack_o <= 1'b1;
                        end
                        if (phase_q == P_RD) begin
                            for (int k = 0; k < MAX_BYTES; k++) begin
                                if (idx_q == LW'(k)) begin
                                    rdata_o[8*k +: 8] <= m_dout_i;
                                end
                            end
                        end
                    end

                    if (state_q == S_WAIT_LO) begin
                        if (!m_ready_i) begin
                            state_q <= S_WAIT_HI;
                        end
                    end else if (m_ready_i) begin
                        if (phase_q == P_STOP) begin
                            done_o  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ISSUE;
                            if (nack_o || ack_fail_c) begin
                                phase_q <= P_STOP;
                            end else begin
                                case (phase_q)
                                    P_START: phase_q <= P_ADDRW;
                                    P_ADDRW: phase_q <= P_REG;
                                    P_REG: begin
                                        idx_q <= '0;
                                        // A zero-length read degenerates to a write
                                        // of no data bytes.
                                        if (len_q == '0) begin
                                            phase_q <= P_STOP;
                                        end else if (rnw_q) begin
                                            phase_q <= P_RESTART;
                                        end else begin
                                            phase_q <= P_WDATA;
                                        end
                                    end
                                    P_WDATA, P_RD: begin
                                        if (last_c) begin
                                            phase_q <= P_STOP;
                                        end else begin
                                            idx_q <= idx_q + LW'(1);
                                        end
                                    end
                                    P_RESTART: phase_q <= P_ADDRR;
                                    P_ADDRR: begin
                                        idx_q   <= '0;
                                        phase_q <= P_RD;
                                    end
                                    default: phase_q <= P_STOP;
                                endcase
                            end
                        end
                    end
                end

                S_DONE: begin
                    busy_o  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
